// File: rtl/mesh_adapter_job_pe_match_initiator.sv
// Initiator end of the job PE <-> shared match PE mesh link: packs match requests
// into mesh packets, unpacks returning match lengths, and tracks lazy slots in flight.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef LAZY_LEN_LOG2
`define LAZY_LEN_LOG2 3
`endif
`ifndef MATCH_LEN_WIDTH
`define MATCH_LEN_WIDTH 8
`endif
`ifndef MESH_X_SIZE_LOG2
`define MESH_X_SIZE_LOG2 2
`endif
`ifndef MESH_Y_SIZE_LOG2
`define MESH_Y_SIZE_LOG2 2
`endif
`ifndef MESH_W
`define MESH_W 64
`endif

module mesh_adapter_job_pe_match_initiator_chk #(
    parameter int MY_Y = 0
) (
    input logic clk,
    input logic rst_n,
    input logic from_fire,
    input logic tag_busy
);
    // The return tag drops MY_Y[0], so an odd row cannot be reached by responses.
    if ((MY_Y % 2) != 0) begin : g_bad_my_y
        $fatal(1, "mesh_adapter_job_pe_match_initiator: MY_Y must be even");
    end

    // A returning packet must name a lazy slot that is actually in flight.
    always @(posedge clk) begin
        if (rst_n && from_fire) begin
            assert (tag_busy) else $fatal(1, "mesh_adapter_job_pe_match_initiator: response for idle tag");
        end
    end
endmodule

module mesh_adapter_job_pe_match_initiator #(
    parameter int MY_X            = 0,
    parameter int MY_Y            = 0,
    parameter int MATCH_PE_X      = 0,
    parameter int MATCH_PE_Y      = 1,
    parameter int MAX_OUTSTANDING = (1 << `LAZY_LEN_LOG2)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          match_req_valid,
    output logic                          match_req_ready,
    input  logic [`ADDR_WIDTH-1:0]        match_req_head_addr,
    input  logic [`ADDR_WIDTH-1:0]        match_req_history_addr,
    input  logic [`LAZY_LEN_LOG2-1:0]     match_req_tag,
    output logic                          match_resp_valid,
    input  logic                          match_resp_ready,
    output logic [`LAZY_LEN_LOG2-1:0]     match_resp_tag,
    output logic [`MATCH_LEN_WIDTH-1:0]   match_resp_match_len,
    output logic                          to_mesh_valid,
    input  logic                          to_mesh_ready,
    output logic [`MESH_X_SIZE_LOG2-1:0]  to_mesh_x_dst,
    output logic [`MESH_Y_SIZE_LOG2-1:0]  to_mesh_y_dst,
    output logic [`MESH_W-1:0]            to_mesh_payload,
    input  logic                          from_mesh_valid,
    output logic                          from_mesh_ready,
    input  logic [`MESH_W-1:0]            from_mesh_payload
);
    localparam int TW    = `LAZY_LEN_LOG2;
    localparam int NT    = 1 << TW;
    localparam int AW    = `ADDR_WIDTH;
    localparam int LW    = `MATCH_LEN_WIDTH;
    localparam int XW    = `MESH_X_SIZE_LOG2;
    localparam int YW    = `MESH_Y_SIZE_LOG2;
    localparam int MW    = `MESH_W;
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int REQ_W = 2 * AW + TW + (YW - 1) + XW;

    localparam logic [XW-1:0] MY_X_C      = XW'(MY_X);
    localparam logic [YW-1:0] MY_Y_C      = YW'(MY_Y);
    localparam logic [XW-1:0] PE_X_C      = XW'(MATCH_PE_X);
    localparam logic [YW-1:0] PE_Y_C      = YW'(MATCH_PE_Y);
    localparam logic [OW-1:0] MAX_OUT_C   = OW'(MAX_OUTSTANDING);
    localparam logic [OW-1:0] ONE_C       = OW'(1);

    logic [NT-1:0]  busy_r;
    logic [OW-1:0]  outstanding_r;
    logic           to_mesh_valid_r;
    logic [MW-1:0]  to_mesh_payload_r;
    logic           match_resp_valid_r;
    logic [TW-1:0]  match_resp_tag_r;
    logic [LW-1:0]  match_resp_len_r;

    logic           req_ready_s;
    logic           from_ready_s;
    logic           req_fire_s;
    logic           from_fire_s;
    logic           resp_fire_s;
    logic           from_busy_s;
    logic [TW-1:0]  from_tag_s;
    logic [LW-1:0]  from_len_s;
    logic [MW-1:0]  req_pkt_s;
    logic           unused_payload_s;

    assign unused_payload_s = ^from_mesh_payload[MW-1:TW+LW];

    // Handshake qualification and packet formatting; busy is checked without bypass.
    always_comb begin
        from_tag_s   = from_mesh_payload[TW-1:0];
        from_len_s   = from_mesh_payload[TW +: LW];
        from_busy_s  = busy_r[from_tag_s];
        req_ready_s  = !busy_r[match_req_tag] && (outstanding_r < MAX_OUT_C)
                       && (!to_mesh_valid_r || to_mesh_ready);
        from_ready_s = !match_resp_valid_r || match_resp_ready;
        req_fire_s   = match_req_valid && req_ready_s;
        from_fire_s  = from_mesh_valid && from_ready_s;
        resp_fire_s  = from_fire_s && from_busy_s;
        req_pkt_s    = {{(MW - REQ_W){1'b0}}, match_req_head_addr, match_req_history_addr,
                        match_req_tag, MY_Y_C[YW-1:1], MY_X_C};
    end

    // Lazy-slot scoreboard: set and clear can never target the same bit in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r        <= '0;
            outstanding_r <= '0;
        end else begin
            if (req_fire_s) begin
                busy_r[match_req_tag] <= 1'b1;
            end
            if (resp_fire_s) begin
                busy_r[from_tag_s] <= 1'b0;
            end
            case ({req_fire_s, resp_fire_s})
                2'b10:   outstanding_r <= outstanding_r + ONE_C;
                2'b01:   outstanding_r <= outstanding_r - ONE_C;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Outbound request register, held until the mesh takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_mesh_valid_r   <= 1'b0;
            to_mesh_payload_r <= '0;
        end else if (req_fire_s) begin
            to_mesh_valid_r   <= 1'b1;
            to_mesh_payload_r <= req_pkt_s;
        end else if (to_mesh_ready) begin
            to_mesh_valid_r   <= 1'b0;
        end
    end

    // Response register; packets for idle tags are consumed but never forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_resp_valid_r <= 1'b0;
            match_resp_tag_r   <= '0;
            match_resp_len_r   <= '0;
        end else if (resp_fire_s) begin
            match_resp_valid_r <= 1'b1;
            match_resp_tag_r   <= from_tag_s;
            match_resp_len_r   <= from_len_s;
        end else if (match_resp_ready) begin
            match_resp_valid_r <= 1'b0;
        end
    end

    assign match_req_ready      = req_ready_s;
    assign from_mesh_ready      = from_ready_s;
    assign to_mesh_valid        = to_mesh_valid_r;
    assign to_mesh_payload      = to_mesh_payload_r;
    assign to_mesh_x_dst        = PE_X_C;
    assign to_mesh_y_dst        = PE_Y_C;
    assign match_resp_valid     = match_resp_valid_r;
    assign match_resp_tag       = match_resp_tag_r;
    assign match_resp_match_len = match_resp_len_r;

    mesh_adapter_job_pe_match_initiator_chk #(
        .MY_Y(MY_Y)
    ) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .from_fire(from_fire_s),
        .tag_busy (from_busy_s)
    );
endmodule
